seven_seg_scan_driver: RTL and testbench
========================================

SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 1000: SHOW-slot length per digit, in Clk cycles; legal range 2..65535.
REQ-002 Parameter BLANK_CYCLES, default 4: BLANK-slot length before each digit, in Clk cycles; legal range 1..255.
REQ-003 Clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Load  input  1  one-cycle strobe; SegDig1/SegDig2 valid when high.
REQ-006 SegDig1  input  8  segment pattern for digit 0, bit0=a .. bit6=g, bit7=dp, 1=lit.
REQ-007 SegDig2  input  8  segment pattern for digit 1, same encoding.
REQ-008 Brightness  input  4  duty level 0..15; 0=dark.
REQ-009 SegOut  output  8  shared segment bus, registered.
REQ-010 DigitEn  output  2  one-hot digit enable, bit0=digit 0, registered, active-high.
REQ-011 LoadAck  output  1  one-cycle pulse when a pending pattern pair becomes active.

Function
REQ-012 The controller SHALL cycle through four states in fixed order: BLANK0 -> SHOW0 -> BLANK1 -> SHOW1 -> BLANK0.
REQ-013 Each BLANK state SHALL last exactly BLANK_CYCLES cycles; each SHOW state exactly REFRESH_DIV cycles; frame = 2*(BLANK_CYCLES+REFRESH_DIV) cycles.
REQ-014 In BLANK states DigitEn SHALL be 2'b00 and SegOut 8'h00.
REQ-015 In SHOW0 DigitEn SHALL be 2'b01; in SHOW1 2'b10; never both bits high.
REQ-016 Brightness SHALL be sampled on the edge entering each SHOW state and held for that slot.
REQ-017 A 4-bit phase counter SHALL reset to 0 on entering each SHOW state and increment every SHOW cycle, wrapping 15->0.
REQ-018 During SHOWn SegOut SHALL equal active pattern n when phase < sampled Brightness, else 8'h00; DigitEn stays asserted for the whole slot.
REQ-019 Load high at an edge SHALL copy SegDig1/SegDig2 into pending registers and set a pending flag; a later Load before application overwrites pending (last wins).
REQ-020 Frame boundary = edge leaving SHOW1; if the pending flag was set before that edge, pending SHALL copy to active, the flag SHALL clear, and LoadAck SHALL be high for the first BLANK0 cycle only.
REQ-021 Active patterns SHALL change only at a frame boundary; no torn frame (digit 0 and digit 1 from different loads).
REQ-022 Load coincident with the frame-boundary edge: active takes the previous pending contents (only if the flag was already set; LoadAck as REQ-020); the new data goes to pending with the flag left set, applied at the next boundary.
REQ-023 With the flag clear at a boundary, active SHALL be unchanged and LoadAck SHALL stay low.
REQ-024 Brightness changes mid-slot SHALL not affect the current slot.

Reset
REQ-025 Rst_n low SHALL immediately force SegOut=8'h00, DigitEn=2'b00, LoadAck=0, active and pending registers=0, pending flag=0, phase and slot counters=0, state=BLANK0.
REQ-026 After Rst_n rises, the first rising Clk edge SHALL count as BLANK0 cycle 1.
REQ-027 Rst_n asserted mid-SHOW or with a load pending SHALL discard all pending and active data; no LoadAck follows reset.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-028 Reset release, no Load, Brightness=15 -> DigitEn sequence 00,00, 01x8, 00,00, 10x8 repeating with period 20; SegOut 00 throughout.
REQ-029 Load with SegDig1=8'b00111111, SegDig2=8'b01111101 during SHOW0, Brightness=15 -> LoadAck one cycle at next BLANK0; next SHOW0 SegOut=00111111 for phases 0..7; SHOW1 SegOut=01111101.
REQ-030 Brightness=4, pattern 8'hFF on digit 0 -> SegOut=FF on SHOW0 cycles 1-4, 00 on cycles 5-8; Brightness=0 -> SegOut 00 all frame, DigitEn still scanning.
REQ-031 Two Loads (0x11/0x22 then 0x33/0x44) in one frame -> single LoadAck; active becomes 0x33/0x44; 0x11 never on SegOut.
REQ-032 Load 0xAA/0x55 on the SHOW1->BLANK0 edge with the flag clear -> no LoadAck that boundary; LoadAck and 0xAA/0x55 display one frame later.
REQ-033 Rst_n pulsed low mid-SHOW1 with a load pending -> outputs 0 immediately; after release LoadAck never pulses and SegOut stays 00.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// Two-digit multiplexed seven-segment driver. It scans BLANK0/SHOW0/BLANK1/SHOW1,
// applies PWM brightness inside each SHOW slot, and double-buffers pattern loads up to the frame boundary.
module seven_seg_scan_driver #(
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Load,
  input  logic [7:0] SegDig1,
  input  logic [7:0] SegDig2,
  input  logic [3:0] Brightness,
  output logic [7:0] SegOut,
  output logic [1:0] DigitEn,
  output logic       LoadAck,
  output logic [1:0] state_dbg
);

  // Load is a one-cycle strobe with no back-pressure: data is always accepted
  // into the pending pair on the edge where Load is high, and LoadAck pulses
  // once on the first BLANK0 cycle after that pair is promoted to active.

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW0  = 2'd1,
    BLANK1 = 2'd2,
    SHOW1  = 2'd3
  } state_t;

  localparam logic [15:0] SHOW_LEN  = 16'(REFRESH_DIV);
  localparam logic [15:0] BLANK_LEN = 16'(BLANK_CYCLES);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  phase_q, phase_d;
  logic [3:0]  bright_q, bright_d;
  logic [7:0]  act0_q, act1_q, pend0_q, pend1_q;
  logic        pend_flag_q;
  logic        is_show, slot_done, boundary;
  logic [7:0]  seg_d;
  logic [1:0]  en_d;

  assign is_show   = (state_q == SHOW0) || (state_q == SHOW1);
  // cnt_q counts cycles already spent in the current slot (0 only out of reset)
  assign slot_done = (cnt_q == (is_show ? SHOW_LEN : BLANK_LEN));
  assign state_dbg = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 16'd1;
    phase_d  = is_show ? phase_q + 4'd1 : phase_q;
    bright_d = bright_q;
    boundary = 1'b0;
    if (slot_done) begin
      cnt_d   = 16'd1;
      phase_d = 4'd0;
      case (state_q)
        BLANK0: begin
          state_d  = SHOW0;
          bright_d = Brightness;
        end
        SHOW0:  state_d = BLANK1;
        BLANK1: begin
          state_d  = SHOW1;
          bright_d = Brightness;
        end
        SHOW1: begin
          state_d  = BLANK0;
          boundary = 1'b1;
        end
        default: state_d = BLANK0;
      endcase
    end
  end

  // Outputs are registered from next-state values so they line up with the slot
  always_comb begin
    seg_d = 8'h00;
    en_d  = 2'b00;
    case (state_d)
      SHOW0: begin
        en_d = 2'b01;
        if (phase_d < bright_d) seg_d = act0_q;
      end
      SHOW1: begin
        en_d = 2'b10;
        if (phase_d < bright_d) seg_d = act1_q;
      end
      default: begin
        seg_d = 8'h00;
        en_d  = 2'b00;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= BLANK0;
      cnt_q    <= 16'd0;
      phase_q  <= 4'd0;
      bright_q <= 4'd0;
      SegOut   <= 8'h00;
      DigitEn  <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      bright_q <= bright_d;
      SegOut   <= seg_d;
      DigitEn  <= en_d;
    end
  end

  // A Load on the boundary edge lands in pending while the old pending is promoted
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      act0_q      <= 8'h00;
      act1_q      <= 8'h00;
      pend0_q     <= 8'h00;
      pend1_q     <= 8'h00;
      pend_flag_q <= 1'b0;
      LoadAck     <= 1'b0;
    end else begin
      if (boundary && pend_flag_q) begin
        act0_q  <= pend0_q;
        act1_q  <= pend1_q;
        LoadAck <= 1'b1;
      end else begin
        LoadAck <= 1'b0;
      end
      if (Load) begin
        pend0_q     <= SegDig1;
        pend1_q     <= SegDig2;
        pend_flag_q <= 1'b1;
      end else if (boundary) begin
        pend_flag_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver (REFRESH_DIV=8, BLANK_CYCLES=2) against a
// frame-position reference model, with directed scenarios and random traffic.
module tb_seven_seg_scan_driver;

  localparam int R = 8;
  localparam int B = 2;
  localparam int F = 2 * (B + R);

  logic       Clk, Rst_n, Load;
  logic [7:0] SegDig1, SegDig2;
  logic [3:0] Brightness;
  logic [7:0] SegOut;
  logic [1:0] DigitEn;
  logic       LoadAck;
  logic [1:0] state_dbg;

  seven_seg_scan_driver #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Load(Load), .SegDig1(SegDig1), .SegDig2(SegDig2),
    .Brightness(Brightness), .SegOut(SegOut), .DigitEn(DigitEn), .LoadAck(LoadAck),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: k = cycles since reset release, everything derived from frame position
  int         k;
  logic [7:0] m_act[2];
  logic [7:0] m_pend[2];
  bit         m_flag;
  logic [3:0] m_br;
  logic       m_ack;
  logic [3:0] cur_br;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %02h expected %02h", tag, k, got, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    m_act[0] = 8'h00; m_act[1] = 8'h00;
    m_pend[0] = 8'h00; m_pend[1] = 8'h00;
    m_flag = 1'b0; m_br = 4'd0; m_ack = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_seg"}, SegOut, 8'h00);
    check({tag, "_en"}, {6'd0, DigitEn}, 8'h00);
    check({tag, "_ack"}, {7'd0, LoadAck}, 8'h00);
  endtask

  // driver: apply inputs for one edge, advance the model, compare after the edge
  task automatic step(input logic ld, input logic [7:0] d1, input logic [7:0] d2,
                      input logic [3:0] br);
    int p, j, digit;
    logic [7:0] exp_seg;
    logic [1:0] exp_en;
    Load = ld; SegDig1 = d1; SegDig2 = d2; Brightness = br;
    @(posedge Clk);
    k++;
    p = (k - 1) % F;
    m_ack = 1'b0;
    if (p == 0 && k > 1 && m_flag) begin
      m_act[0] = m_pend[0];
      m_act[1] = m_pend[1];
      m_flag = 1'b0;
      m_ack = 1'b1;
    end
    if (ld) begin
      m_pend[0] = d1;
      m_pend[1] = d2;
      m_flag = 1'b1;
    end
    if (p == B || p == 2 * B + R) m_br = br;
    exp_seg = 8'h00;
    exp_en = 2'b00;
    digit = -1;
    j = 0;
    if (p >= B && p < B + R) begin
      digit = 0; j = p - B;
    end else if (p >= 2 * B + R) begin
      digit = 1; j = p - (2 * B + R);
    end
    if (digit >= 0) begin
      exp_en = (digit == 0) ? 2'b01 : 2'b10;
      if ((j % 16) < int'(m_br)) exp_seg = m_act[digit];
    end
    #1;
    check("seg", SegOut, exp_seg);
    check("digit_en", {6'd0, DigitEn}, {6'd0, exp_en});
    check("load_ack", {7'd0, LoadAck}, {7'd0, m_ack});
    Load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, cur_br);
  endtask

  // idle until the next edge lands on frame position target
  task automatic run_to(input int target);
    for (int i = 0; i < F && (k % F) != target; i++) step(1'b0, 8'h00, 8'h00, cur_br);
  endtask

  initial begin
    Rst_n = 1'b1; Load = 1'b0; SegDig1 = 8'h00; SegDig2 = 8'h00; Brightness = 4'd0;
    cur_br = 4'd15;
    model_reset();
    #2 Rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();

    // blank scan, full brightness
    idle(2 * F);

    // load during SHOW0
    run_to(B + 3);
    step(1'b1, 8'b0011_1111, 8'b0111_1101, cur_br);
    idle(2 * F);

    // partial and zero brightness
    run_to(B + R + 1);
    step(1'b1, 8'hFF, 8'h0F, cur_br);
    cur_br = 4'd4;
    idle(2 * F);
    cur_br = 4'd0;
    idle(F);
    cur_br = 4'd15;

    // two loads in one frame, last wins
    run_to(B + 1);
    step(1'b1, 8'h11, 8'h22, cur_br);
    idle(3);
    step(1'b1, 8'h33, 8'h44, cur_br);
    idle(2 * F);

    // load coincident with the boundary edge, flag clear
    run_to(0);
    step(1'b1, 8'hAA, 8'h55, cur_br);
    idle(2 * F);

    // reset mid-SHOW1 with a load pending
    run_to(2 * B + R + 1);
    step(1'b1, 8'hC3, 8'h3C, cur_br);
    idle(2);
    #2 Rst_n = 1'b0;
    #1 check_zero("mid_reset");
    repeat (3) begin
      @(posedge Clk);
      #1 check_zero("held_reset");
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();
    idle(2 * F);

    // random loads and brightness changes
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) == 0), 8'($urandom), 8'($urandom),
           4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
